reset_sequencer: RTL and testbench

Parametrised reset synchroniser and release sequencer. Takes the board-level asynchronous active-high reset, asserts every reset output immediately and asynchronously, and synchronises deassertion through a configurable flop chain. It then releases NUM_OUTPUTS reset domains one at a time after a programmable hold-off. A synchronous software reset request restarts the release sequence. It sits at the top level and feeds pipeline stages, memories and peripherals in a defined wake-up order.

---
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset synchroniser plus ordered release of NUM_OUTPUTS reset domains.
// Assertion is asynchronous everywhere; deassertion is synchronised, held off, then staggered.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_OUTPUTS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  output logic [NUM_OUTPUTS-1:0] rst_out,
  output logic                   sync_reset,
  output logic                   reset_done
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(NUM_OUTPUTS) + 1;

  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] ONE_HOT0  = NUM_OUTPUTS'(1);

  typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RELEASE, S_DONE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [NUM_OUTPUTS-1:0] rst_next;
  logic                   done_next;

  // Clears one domain bit; released bits stay cleared, so rst_out remains a thermometer code.
  function automatic logic [NUM_OUTPUTS-1:0] release_bit(input logic [NUM_OUTPUTS-1:0] cur,
                                                         input logic [IDX_W-1:0] bit_idx);
    return cur & ~(ONE_HOT0 << bit_idx);
  endfunction

  // Synchroniser: async set, shifts in 0 once reset drops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign sync_reset = sync_q[SYNC_STAGES-1];

  // Sequencer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_out    <= '1;
      reset_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      rst_out    <= rst_next;
      reset_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    rst_next   = rst_out;
    done_next  = reset_done;

    case (state)
      S_ASSERT: begin
        if (!sync_reset) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          rst_next = release_bit(rst_out, '0);
          cnt_next = '0;
          if (NUM_OUTPUTS == 1) begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            idx_next   = IDX_W'(1);
            state_next = S_RELEASE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt == STAG_LAST) begin
          rst_next = release_bit(rst_out, idx);
          cnt_next = '0;
          if (idx == IDX_LAST) begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Software request restarts the hold-off but leaves the synchroniser alone
    if (sw_reset_req && (state != S_ASSERT)) begin
      rst_next   = '1;
      done_next  = 1'b0;
      state_next = S_HOLD;
      cnt_next   = '0;
      idx_next   = '0;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus two parameter-sweep instances.
`timescale 1ns/100ps
module tb_reset_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic sw_reset_req;

  logic [3:0] rst_out;
  logic       sync_reset, reset_done;
  logic [0:0] p1_rst_out;
  logic       p1_sync, p1_done;
  logic [7:0] p8_rst_out;
  logic       p8_sync, p8_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  reset_sequencer dut (
    .clock(clock), .reset(reset), .sw_reset_req(sw_reset_req),
    .rst_out(rst_out), .sync_reset(sync_reset), .reset_done(reset_done)
  );

  reset_sequencer #(.SYNC_STAGES(3), .NUM_OUTPUTS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut_p1 (
    .clock(clock), .reset(reset), .sw_reset_req(1'b0),
    .rst_out(p1_rst_out), .sync_reset(p1_sync), .reset_done(p1_done)
  );

  reset_sequencer #(.SYNC_STAGES(2), .NUM_OUTPUTS(8), .HOLD_CYCLES(16), .STAGGER_CYCLES(2)) dut_p8 (
    .clock(clock), .reset(reset), .sw_reset_req(1'b0),
    .rst_out(p8_rst_out), .sync_reset(p8_sync), .reset_done(p8_done)
  );

  // Expected default rst_out given edges elapsed since the edge that entered HOLD.
  function automatic logic [3:0] exp4(input int rel);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = !(rel >= 16 + 4 * k);
    return r;
  endfunction

  // Stimulus only: pulse reset across an edge, drop it mid-cycle so the next posedge is E0.
  task automatic start_seq();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw_reset_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL reset_rst_out got %b want 1111", rst_out); end
    n_checks++;
    if (sync_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sync got %b want 1", sync_reset); end
    n_checks++;
    if (reset_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", reset_done); end
  endtask

  task automatic test_power_on();
    start_seq();
    for (int e = 0; e <= 33; e++) begin
      @(posedge clock); #1;
      n_checks++;
      if (sync_reset !== (e < 1)) begin
        n_fail++; $display("FAIL pwr_sync E%0d got %b want %b", e, sync_reset, (e < 1));
      end
      n_checks++;
      if (rst_out !== exp4(e - 2)) begin
        n_fail++; $display("FAIL pwr_rst_out E%0d got %b want %b", e, rst_out, exp4(e - 2));
      end
      n_checks++;
      if (reset_done !== (e >= 30)) begin
        n_fail++; $display("FAIL pwr_done E%0d got %b want %b", e, reset_done, (e >= 30));
      end
    end
  endtask

  task automatic test_async_mid();
    start_seq();
    repeat (24) @(posedge clock);
    #1;
    n_checks++;
    if (rst_out !== 4'b1100) begin n_fail++; $display("FAIL mid_pre got %b want 1100", rst_out); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL mid_async_rst_out got %b want 1111", rst_out); end
    n_checks++;
    if (sync_reset !== 1'b1) begin n_fail++; $display("FAIL mid_async_sync got %b want 1", sync_reset); end
    n_checks++;
    if (reset_done !== 1'b0) begin n_fail++; $display("FAIL mid_async_done got %b want 0", reset_done); end
    @(negedge clock);
    reset = 1'b0;
    for (int e = 0; e <= 31; e++) begin
      @(posedge clock); #1;
      n_checks++;
      if (rst_out !== exp4(e - 2) || reset_done !== (e >= 30)) begin
        n_fail++;
        $display("FAIL mid_restart E%0d got %b/%b want %b/%b", e, rst_out, reset_done, exp4(e - 2), (e >= 30));
      end
    end
  endtask

  task automatic test_sw_done();
    // Sequence from the previous task is complete: DONE state.
    @(negedge clock);
    sw_reset_req = 1'b1;
    @(posedge clock); #1;
    sw_reset_req = 1'b0;
    n_checks++;
    if (rst_out !== 4'b1111 || reset_done !== 1'b0) begin
      n_fail++; $display("FAIL sw_done_ek got %b/%b want 1111/0", rst_out, reset_done);
    end
    for (int j = 1; j <= 30; j++) begin
      @(posedge clock); #1;
      n_checks++;
      if (rst_out !== exp4(j) || reset_done !== (j >= 28)) begin
        n_fail++;
        $display("FAIL sw_done Ek+%0d got %b/%b want %b/%b", j, rst_out, reset_done, exp4(j), (j >= 28));
      end
      n_checks++;
      if (sync_reset !== 1'b0) begin n_fail++; $display("FAIL sw_done_sync Ek+%0d got %b want 0", j, sync_reset); end
    end
  endtask

  task automatic test_sw_held();
    start_seq();
    repeat (21) @(posedge clock);
    #1;
    n_checks++;
    if (rst_out !== 4'b1110) begin n_fail++; $display("FAIL held_pre got %b want 1110", rst_out); end
    @(negedge clock);
    sw_reset_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL held_during cyc%0d got %b want 1111", i, rst_out); end
    end
    sw_reset_req = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clock); #1;
      n_checks++;
      if (rst_out !== exp4(j)) begin
        n_fail++; $display("FAIL held_after Ek+%0d got %b want %b", j, rst_out, exp4(j));
      end
    end
  endtask

  task automatic test_sw_in_assert();
    start_seq();
    sw_reset_req = 1'b1;
    for (int e = 0; e <= 31; e++) begin
      @(posedge clock); #1;
      if (e == 1) sw_reset_req = 1'b0;
      n_checks++;
      if (rst_out !== exp4(e - 2) || reset_done !== (e >= 30)) begin
        n_fail++;
        $display("FAIL sw_assert E%0d got %b/%b want %b/%b", e, rst_out, reset_done, exp4(e - 2), (e >= 30));
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] exp8;
    start_seq();
    for (int e = 0; e <= 34; e++) begin
      @(posedge clock); #1;
      if (e <= 6) begin
        n_checks++;
        if (p1_sync !== (e < 2)) begin n_fail++; $display("FAIL p1_sync E%0d got %b want %b", e, p1_sync, (e < 2)); end
        n_checks++;
        if (p1_rst_out[0] !== (e < 4) || p1_done !== (e >= 4)) begin
          n_fail++; $display("FAIL p1_release E%0d got %b/%b want %b/%b", e, p1_rst_out[0], p1_done, (e < 4), (e >= 4));
        end
      end
      for (int k = 0; k < 8; k++) exp8[k] = !(e >= 18 + 2 * k);
      n_checks++;
      if (p8_rst_out !== exp8 || p8_done !== (e >= 32)) begin
        n_fail++; $display("FAIL p8_release E%0d got %b/%b want %b/%b", e, p8_rst_out, p8_done, exp8, (e >= 32));
      end
    end
  endtask

  task automatic test_short_pulse();
    @(negedge clock);
    #2 reset = 1'b1;
    #0.5;
    n_checks++;
    if (rst_out !== 4'b1111 || sync_reset !== 1'b1 || reset_done !== 1'b0) begin
      n_fail++; $display("FAIL short_assert got %b/%b/%b want 1111/1/0", rst_out, sync_reset, reset_done);
    end
    #0.5 reset = 1'b0;
    for (int e = 0; e <= 31; e++) begin
      @(posedge clock); #1;
      n_checks++;
      if (rst_out !== exp4(e - 2) || reset_done !== (e >= 30)) begin
        n_fail++;
        $display("FAIL short_seq E%0d got %b/%b want %b/%b", e, rst_out, reset_done, exp4(e - 2), (e >= 30));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_async_mid();
    test_sw_done();
    test_sw_held();
    test_sw_in_assert();
    test_param_sweep();
    test_short_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
